branch_pc_ctrl: RTL

//  Branch-resolution and PC-generation stage, directly downstream of the EX branch comparator.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_taken_dec.sv | 34 +++
 rtl/branch_pc_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch-resolution / PC-generation stage.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_type_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
  endfunction

endpackage

// File: rtl/branch_taken_dec.sv
// Combinational taken/not-taken decode from funct3, jump flags and comparator flags.
module branch_taken_dec
  import branch_pkg::*;
(
  input  logic [2:0] br_type_i,
  input  logic       is_jal_i,
  input  logic       is_jalr_i,
  input  logic       br_less_i,
  input  logic       br_equal_i,
  output logic       taken_o
);

  logic w_cond;

  // Unsigned variants share the less flag; the comparator is switched via br_type_i[1].
  always_comb begin
    w_cond = 1'b0;
    case (br_type_i)
      BEQ:     w_cond = br_equal_i;
      BNE:     w_cond = ~br_equal_i;
      BLT:     w_cond = br_less_i;
      BGE:     w_cond = ~br_less_i;
      BLTU:    w_cond = br_less_i;
      BGEU:    w_cond = ~br_less_i;
      default: w_cond = 1'b0;
    endcase
    if (is_jal_i | is_jalr_i) begin
      taken_o = 1'b1;
    end else begin
      taken_o = w_cond;
    end
  end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Branch resolution, fetch PC register and redirect/flush control.
// Optional branch statistics counters are built when BRANCH_PERF_EN is defined.
module branch_pc_ctrl
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        imem_ready_i,
  input  logic        br_valid_i,
  input  logic [2:0]  br_type_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  input  logic [31:0] br_target_i,
  output logic        br_unsigned_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_four_o,
  output logic        redirect_o,
  output logic        flush_o,
  output logic        misalign_o,
  output logic [31:0] perf_br_total_o,
  output logic [31:0] perf_br_taken_o
);

  localparam logic [31:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 32'(FLUSH_CYCLES - 2) : 32'd0;
  localparam logic        FLUSH_FSM  = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;

  pc_state_e   r_state;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_pc;

  logic        w_taken;
  logic [31:0] w_target;
  logic        w_eval;
  logic        w_aligned;
  logic        w_redirect;
  logic        w_misalign;

  branch_taken_dec u_taken_dec (
    .br_type_i  (br_type_i),
    .is_jal_i   (is_jal_i),
    .is_jalr_i  (is_jalr_i),
    .br_less_i  (br_less_i),
    .br_equal_i (br_equal_i),
    .taken_o    (w_taken)
  );

  assign w_target   = is_jalr_i ? {br_target_i[31:1], 1'b0} : br_target_i;
  assign w_eval     = br_valid_i & ~stall_i & (r_state == RUN);
  assign w_aligned  = is_word_aligned(w_target[1:0]);
  assign w_redirect = w_eval & w_taken & w_aligned;
  assign w_misalign = w_eval & w_taken & ~w_aligned;

  assign br_unsigned_o = br_type_i[1];
  assign redirect_o    = w_redirect;
  assign misalign_o    = w_misalign;
  assign flush_o       = w_redirect | w_misalign | (r_state == FLUSH);
  assign pc_o          = r_pc;
  assign pc_four_o     = r_pc + PC_STEP;

  // Fetch PC: a resolved branch or trap overrides both stall and memory back-pressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_misalign) begin
      r_pc <= TRAP_VEC;
    end else if (stall_i) begin
      r_pc <= r_pc;
    end else if (imem_ready_i) begin
      r_pc <= r_pc + PC_STEP;
    end else begin
      r_pc <= r_pc;
    end
  end

  // Flush sequencer; the redirect cycle itself is the first flush cycle, and stall does not extend it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_flush_cnt <= 32'd0;
    end else begin
      case (r_state)
        RUN: begin
          if ((w_redirect | w_misalign) && FLUSH_FSM) begin
            r_state     <= FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
          end else begin
            r_state     <= RUN;
            r_flush_cnt <= r_flush_cnt;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == 32'd0) begin
            r_state     <= RUN;
            r_flush_cnt <= 32'd0;
          end else begin
            r_state     <= FLUSH;
            r_flush_cnt <= r_flush_cnt - 32'd1;
          end
        end
        default: begin
          r_state     <= RUN;
          r_flush_cnt <= 32'd0;
        end
      endcase
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] r_br_total;
  logic [31:0] r_br_taken;
  logic        w_cond_eval;

  assign w_cond_eval = w_eval & ~is_jal_i & ~is_jalr_i;

  // Misaligned conditional branches still count as taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_br_total <= 32'd0;
      r_br_taken <= 32'd0;
    end else if (w_cond_eval) begin
      r_br_total <= sat_inc(r_br_total);
      r_br_taken <= w_taken ? sat_inc(r_br_taken) : r_br_taken;
    end else begin
      r_br_total <= r_br_total;
      r_br_taken <= r_br_taken;
    end
  end

  assign perf_br_total_o = r_br_total;
  assign perf_br_taken_o = r_br_taken;
`else
  assign perf_br_total_o = 32'd0;
  assign perf_br_taken_o = 32'd0;
`endif

endmodule
